// File: rtl/demux_tdm4_pkg.sv
// demux_tdm4_pkg
//   Shared constants and state encoding for the 4-slot TDM demultiplexer.
//   SLOTS : slots per frame
//   SEL_W : width of the slot index / remote mux select
//   state_t : HUNT (waiting for a frame marker) / RUN (collecting slots)
package demux_tdm4_pkg;

  localparam int SLOTS = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr
//   Mod-SLOTS slot counter. load1 has priority over en and forces the count
//   to 1; this is the value that follows a slot-0 beat.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, count -> 0
//   en    : advance by one, wrapping SLOTS-1 -> 0
//   load1 : load the count with 1
//   cnt   : current slot index
module tdm_slot_ctr
  import demux_tdm4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load1,
  output logic [SEL_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SEL_W'(1);
    end else if (en) begin
      if (cnt == SEL_W'(SLOTS - 1)) cnt <= '0;
      else                          cnt <= cnt + SEL_W'(1);
    end
  end

endmodule

// File: rtl/demux_tdm4.sv
// demux_tdm4
//   Reconstructs a 4-bit word from a serial TDM stream, one bit per slot.
//   Slots 0..2 go into a shadow register; the slot-3 beat completes the
//   word, which is loaded into q together with a one-cycle q_valid pulse.
//   Parameter SYNC_REQ: 1 = each frame must start with sync,
//                       0 = free-running slot counter, sync only realigns.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   din       : serial slot bit
//   din_valid : din carries a slot beat this cycle
//   sync      : frame marker, marks slot 0 (only meaningful with din_valid)
//   sel       : slot index expected for the next valid beat
//   q         : last complete word, q[k] = slot-k bit
//   q_valid   : one-cycle pulse, q updated
//   err       : one-cycle pulse, framing error
module demux_tdm4
  import demux_tdm4_pkg::*;
#(
  parameter int SYNC_REQ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] sel,
  output logic [SLOTS-1:0] q,
  output logic             q_valid,
  output logic             err
);

  localparam state_t RESET_STATE = (SYNC_REQ != 0) ? HUNT : RUN;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   cnt;
  logic [SLOTS-2:0]   shadow;

  logic               ctr_en;
  logic               ctr_load1;
  logic               shd_we;
  logic [SEL_W-1:0]   shd_idx;
  logic               load_q;
  logic               err_d;

  tdm_slot_ctr u_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (ctr_en),
    .load1 (ctr_load1),
    .cnt   (cnt)
  );

  assign sel = cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (din_valid) begin
      case (state)
        HUNT: if (sync) state_nxt = RUN;
        RUN:  if (!sync && (cnt == '0) && (SYNC_REQ != 0)) state_nxt = HUNT;
        default: state_nxt = RESET_STATE;
      endcase
    end
  end

  // Per-beat action decode. Any sync beat is taken as slot 0; in RUN a sync
  // landing on slots 1..3 also flags the realignment as an error.
  always_comb begin
    ctr_en    = 1'b0;
    ctr_load1 = 1'b0;
    shd_we    = 1'b0;
    shd_idx   = cnt;
    load_q    = 1'b0;
    err_d     = 1'b0;
    if (din_valid) begin
      if (sync) begin
        shd_we    = 1'b1;
        shd_idx   = '0;
        ctr_load1 = 1'b1;
        err_d     = (state == RUN) && (cnt != '0);
      end else if (state == RUN) begin
        if (cnt == '0) begin
          if (SYNC_REQ != 0) begin
            err_d = 1'b1;
          end else begin
            shd_we    = 1'b1;
            shd_idx   = '0;
            ctr_load1 = 1'b1;
          end
        end else if (cnt == SEL_W'(SLOTS - 1)) begin
          load_q = 1'b1;
          ctr_en = 1'b1;
        end else begin
          shd_we = 1'b1;
          ctr_en = 1'b1;
        end
      end
    end
  end

  // Registered datapath: shadow capture, word load and the output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS - 1; i++) begin
        if (shd_we && (shd_idx == SEL_W'(i))) shadow[i] <= din;
      end
      if (load_q) q <= {din, shadow};
      q_valid <= load_q;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_demux_tdm4.sv
module tb_demux_tdm4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       din1 = 1'b0, v1 = 1'b0, s1 = 1'b0;
  logic [1:0] sel1;
  logic [3:0] q1;
  logic       qv1, err1;

  logic       din0 = 1'b0, v0 = 1'b0, s0 = 1'b0;
  logic [1:0] sel0;
  logic [3:0] q0;
  logic       qv0, err0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [3:0] w;
    int         cyc;
  } exp_t;

  exp_t expw1[$];
  exp_t expw0[$];
  int   experr1[$];
  int   experr0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  demux_tdm4 #(.SYNC_REQ(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .sync(s1),
    .sel(sel1), .q(q1), .q_valid(qv1), .err(err1)
  );

  demux_tdm4 #(.SYNC_REQ(0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .sync(s0),
    .sel(sel0), .q(q0), .q_valid(qv0), .err(err0)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitors: every pulse must match the head of its scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (qv1 || err1) chk("excl1", int'(qv1 & err1), 0);
      if (qv1) begin
        if (expw1.size() == 0) chk("qv1_unexpected", int'(qv1), 0);
        else begin
          exp_t e;
          e = expw1.pop_front();
          chk("q1", int'(q1), int'(e.w));
          chk("q1_cycle", cyc, e.cyc);
        end
      end
      if (err1) begin
        if (experr1.size() == 0) chk("err1_unexpected", int'(err1), 0);
        else chk("err1_cycle", cyc, experr1.pop_front());
      end
      if (qv0 || err0) chk("excl0", int'(qv0 & err0), 0);
      if (qv0) begin
        if (expw0.size() == 0) chk("qv0_unexpected", int'(qv0), 0);
        else begin
          exp_t e;
          e = expw0.pop_front();
          chk("q0", int'(q0), int'(e.w));
          chk("q0_cycle", cyc, e.cyc);
        end
      end
      if (err0) begin
        if (experr0.size() == 0) chk("err0_unexpected", int'(err0), 0);
        else chk("err0_cycle", cyc, experr0.pop_front());
      end
    end
  end

  task automatic b1(input logic d, input logic s, input int es);
    @(negedge clk);
    if (es >= 0) chk("sel1", int'(sel1), es);
    din1 = d; v1 = 1'b1; s1 = s;
  endtask

  task automatic idle1(input int n);
    repeat (n) begin
      @(negedge clk);
      din1 = 1'b0; v1 = 1'b0; s1 = 1'b0;
    end
  endtask

  task automatic b0(input logic d, input logic s, input int es);
    @(negedge clk);
    if (es >= 0) chk("sel0", int'(sel0), es);
    din0 = d; v0 = 1'b1; s0 = s;
  endtask

  task automatic idle0(input int n);
    repeat (n) begin
      @(negedge clk);
      din0 = 1'b0; v0 = 1'b0; s0 = 1'b0;
    end
  endtask

  task automatic exp_w1(input logic [3:0] w);
    expw1.push_back('{w: w, cyc: cyc + 1});
  endtask

  task automatic exp_w0(input logic [3:0] w);
    expw0.push_back('{w: w, cyc: cyc + 1});
  endtask

  task automatic exp_e1();
    experr1.push_back(cyc + 1);
  endtask

  // One sync-aligned frame on the SYNC_REQ=1 instance, slot k carries w[k].
  task automatic frame1(input logic [3:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) begin
      b1(w[k], (k == 0), k);
      if (k == 3) exp_w1(w);
      idle1(int'($urandom_range(gap_max, 0)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bits0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_q1", int'(q1), 0);
    chk("rst_qv1", int'(qv1), 0);
    chk("rst_err1", int'(err1), 0);
    chk("rst_sel1", int'(sel1), 0);
    chk("rst_q0", int'(q0), 0);
    chk("rst_sel0", int'(sel0), 0);

    // Basic frame 1,0,1,0 with sel sequence check
    b1(1'b1, 1'b1, 0);
    b1(1'b0, 1'b0, 1);
    b1(1'b1, 1'b0, 2);
    b1(1'b0, 1'b0, 3);
    exp_w1(4'b0101);
    idle1(1);
    chk("sel_wrap", int'(sel1), 0);
    chk("q_basic", int'(q1), 5);
    idle1(2);

    // Back-to-back frames
    frame1(4'b0101, 0);
    frame1(4'b1110, 0);
    idle1(1);
    chk("q_b2b", int'(q1), 14);

    // Sync on the 3rd beat: error, realign from that beat
    b1(1'b1, 1'b1, 0);
    b1(1'b0, 1'b0, 1);
    b1(1'b1, 1'b1, 2);
    exp_e1();
    idle1(1);
    chk("q_hold_realign", int'(q1), 14);
    chk("sel_realign", int'(sel1), 1);
    b1(1'b1, 1'b0, 1);
    b1(1'b0, 1'b0, 2);
    b1(1'b1, 1'b0, 3);
    exp_w1(4'b1011);
    idle1(2);

    // Missing sync on slot 0: error, HUNT, non-sync beats ignored
    b1(1'b0, 1'b0, 0);
    exp_e1();
    b1(1'b1, 1'b0, 0);
    b1(1'b1, 1'b0, 0);
    b1(1'b0, 1'b0, 0);
    idle1(1);
    chk("q_hold_hunt", int'(q1), 11);
    chk("sel_hunt", int'(sel1), 0);
    frame1(4'b1001, 0);
    idle1(1);

    // Idle gaps between beats
    frame1(4'b0101, 3);
    frame1(4'b0110, 3);
    idle1(2);
    chk("q_gaps", int'(q1), 6);

    // Reset after 2 beats
    b1(1'b1, 1'b1, 0);
    b1(1'b1, 1'b0, 1);
    @(negedge clk);
    din1 = 1'b0; v1 = 1'b0; s1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_q", int'(q1), 0);
    chk("midrst_sel", int'(sel1), 0);
    chk("midrst_qv", int'(qv1), 0);
    chk("midrst_err", int'(err1), 0);
    idle1(2);
    frame1(4'b0011, 1);
    idle1(3);

    // Free-running instance, no sync at all
    bits0 = 8'b1110_0011;
    for (int i = 0; i < 8; i++) begin
      b0(bits0[i], 1'b0, i % 4);
      if (i == 3) exp_w0(4'b0011);
      if (i == 7) exp_w0(4'b1110);
    end
    idle0(1);
    chk("q_free", int'(q0), 14);
    chk("sel_free", int'(sel0), 0);
    idle0(3);

    chk("pending_w1", expw1.size(), 0);
    chk("pending_e1", experr1.size(), 0);
    chk("pending_w0", expw0.size(), 0);
    chk("pending_e0", experr0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_tdm4.md
DEMUX_TDM4 -- requirements
Module: demux_tdm4

Interface
REQ-001 Parameter SYNC_REQ, default 1: 1 = every frame must begin with sync; 0 = free-running slot counter that sync only realigns.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din  input  1  serial TDM bit; slot k carries source word bit D[k].
REQ-005 din_valid  input  1  din carries a slot beat this cycle.
REQ-006 sync  input  1  frame marker; meaningful only with din_valid; marks slot 0.
REQ-007 sel  output  2  slot index expected for the next valid beat; drives the remote mux select S.
REQ-008 q  output  4  last complete reconstructed word, q[k] = slot-k bit.
REQ-009 q_valid  output  1  one-cycle pulse: q updated this cycle.
REQ-010 err  output  1  one-cycle pulse: framing error detected.

Function
REQ-011 States: HUNT (waiting for sync) and RUN (collecting slots); slot counter cnt 0..3 drives sel.
REQ-012 Cycles with din_valid=0 shall change no state, counter, shadow or output, except q_valid/err, which return to 0.
REQ-013 HUNT: a beat with sync stores din in shadow[0], sets cnt=1 and enters RUN; a beat without sync is discarded with no err.
REQ-014 RUN, cnt=1..2, no sync: store din in shadow[cnt] and increment cnt.
REQ-015 RUN, cnt=3, no sync: load q = {din, shadow[2], shadow[1], shadow[0]}, pulse q_valid the next cycle (one-cycle latency from the final beat) and wrap cnt to 0.
REQ-016 RUN, cnt=0: with sync, store slot 0 as in REQ-013; without sync and SYNC_REQ=1, pulse err, discard the beat and enter HUNT; without sync and SYNC_REQ=0, accept the beat as slot 0.
REQ-017 RUN, cnt=1..3, sync present: pulse err, discard the partial frame, store the beat as slot 0 and set cnt=1 (realign); q is not updated.
REQ-018 q holds its value between frames; a partial frame never alters q.
REQ-019 q_valid and err are never asserted in the same cycle.

Reset
REQ-020 On rst=1 at a clock edge: q=4'b0000, q_valid=0, err=0, cnt=0 (sel=2'b00), shadow cleared; state = HUNT if SYNC_REQ=1, else RUN.
REQ-021 rst takes priority over every other input; reset mid-frame discards the partial frame and produces no q_valid or err.

Structure
REQ-022 Shared package demux_tdm4_pkg holds SLOTS=4, SEL_W=2, and the state encodings HUNT/RUN.
REQ-023 A single sub-module, tdm_slot_ctr (a mod-SLOTS counter with enable and load-to-1), is natural; everything else stays in demux_tdm4.

Verification
REQ-024 SYNC_REQ=1; beats 1,0,1,0 (sync on first) -> q=4'b0101 and q_valid pulse one cycle after the 4th beat; sel sequence 1,2,3,0.
REQ-025 Back-to-back frames 0101 then 1110 with sync on each slot 0 -> two q_valid pulses exactly 4 valid beats apart; q=4'b0101 then 4'b1110.
REQ-026 Sync asserted on the 3rd beat of a frame -> err pulse, q unchanged, and the next 3 beats complete a new frame from that beat.
REQ-027 SYNC_REQ=1; slot-0 beat without sync after a good frame -> err pulse, HUNT; non-sync beats ignored until the next sync.
REQ-028 din_valid gaps of 0-3 idle cycles between beats -> same q as the gapless case; rst asserted after 2 beats -> all outputs 0, sel=0, no q_valid.
REQ-029 SYNC_REQ=0; no sync at all, 8 beats 1,1,0,0,0,1,1,1 -> q=4'b0011 then 4'b1110, no err.
